// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encodings and widths for the memory port arbiter
package mem_arb_pkg;

  // Width of the wait-state counter (WAIT_CYCLES range 0..15)
  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_F = 2'b01,
    BUSY_D = 2'b10
  } arb_state_e;

endpackage

// File: rtl/mem_arb_wait_cnt.sv
// rtl/mem_arb_wait_cnt.sv - loadable down-counter with zero flag for memory wait states
module mem_arb_wait_cnt
  import mem_arb_pkg::*;
#(
  parameter int W = WAIT_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Load on grant, then count down once per busy cycle, holding at zero
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the single-ported memory between fetch and load/store
// Optional feature macro: MEM_ARB_STARVE_GUARD_EN (forces a fetch grant after STARVE_MAX data grants)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 1,
  parameter int STARVE_MAX  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_rdata,
  output logic              fetch_stall,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_valid,
  output logic [DATA_W-1:0] data_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        r_state;
  logic              r_fetch_gnt;
  logic              r_fetch_valid;
  logic [DATA_W-1:0] r_fetch_rdata;
  logic              r_data_gnt;
  logic              r_data_valid;
  logic [DATA_W-1:0] r_data_rdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_read;
  logic              r_mem_write;

  logic w_idle;
  logic w_force_fetch;
  logic w_grant_d;
  logic w_grant_f;
  logic w_wait_zero;

  assign w_idle = (r_state == IDLE);

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [STARVE_W-1:0] r_starve_cnt;

  // Only force fetch while it is actually requesting, so a stale count never blocks data
  assign w_force_fetch = fetch_req & (r_starve_cnt == STARVE_W'(STARVE_MAX));

  // Count data grants that overtake a waiting fetch; cleared by a fetch grant or an idle fetch side
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_starve_cnt <= '0;
    end else if (!fetch_req || w_grant_f) begin
      r_starve_cnt <= '0;
    end else if (w_grant_d) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end
`else
  assign w_force_fetch = 1'b0;

  // STARVE_MAX only takes effect when the starve guard is built in
  if (STARVE_MAX < 0) begin : g_starve_unused
  end
`endif

  assign w_grant_d = w_idle & data_req & ~w_force_fetch;
  assign w_grant_f = w_idle & fetch_req & (~data_req | w_force_fetch);

  mem_arb_wait_cnt #(
    .W (WAIT_W)
  ) u_wait_cnt (
    .i_clk      (clock),
    .i_rst_n    (reset),
    .i_load     (w_grant_d | w_grant_f),
    .i_load_val (WAIT_W'(WAIT_CYCLES)),
    .i_dec      (~w_idle),
    .o_zero     (w_wait_zero)
  );

  // Access sequencer: grant, hold strobes through the wait states, then capture and pulse valid
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_fetch_gnt   <= 1'b0;
      r_fetch_valid <= 1'b0;
      r_fetch_rdata <= '0;
      r_data_gnt    <= 1'b0;
      r_data_valid  <= 1'b0;
      r_data_rdata  <= '0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
    end else begin
      r_fetch_gnt   <= 1'b0;
      r_fetch_valid <= 1'b0;
      r_data_gnt    <= 1'b0;
      r_data_valid  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_state     <= BUSY_D;
            r_data_gnt  <= 1'b1;
            r_mem_addr  <= data_addr;
            r_mem_wdata <= data_wdata;
            r_mem_read  <= ~data_we;
            r_mem_write <= data_we;
          end else if (w_grant_f) begin
            r_state     <= BUSY_F;
            r_fetch_gnt <= 1'b1;
            r_mem_addr  <= fetch_addr;
            r_mem_wdata <= '0;
            r_mem_read  <= 1'b1;
            r_mem_write <= 1'b0;
          end
        end
        BUSY_F: begin
          if (w_wait_zero) begin
            r_state       <= IDLE;
            r_fetch_rdata <= mem_rdata;
            r_fetch_valid <= 1'b1;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
          end
        end
        BUSY_D: begin
          if (w_wait_zero) begin
            r_state      <= IDLE;
            // Writes leave the last load value in place
            if (r_mem_read) begin
              r_data_rdata <= mem_rdata;
            end
            r_data_valid <= 1'b1;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
        end
      endcase
    end
  end

  assign fetch_gnt   = r_fetch_gnt;
  assign fetch_valid = r_fetch_valid;
  assign fetch_rdata = r_fetch_rdata;
  assign fetch_stall = fetch_req & ~r_fetch_valid;
  assign data_gnt    = r_data_gnt;
  assign data_valid  = r_data_valid;
  assign data_rdata  = r_data_rdata;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int W  = 1;
  localparam int SM = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic       fetch_req = 0, data_req = 0, data_we = 0;
  logic [7:0] fetch_addr = 0, data_addr = 0, data_wdata = 0;
  logic       fetch_gnt, fetch_valid, fetch_stall, data_gnt, data_valid, mem_read, mem_write;
  logic [7:0] fetch_rdata, data_rdata, mem_addr, mem_wdata, mem_rdata;

  logic       z_fetch_req = 0, z_data_req = 0, z_data_we = 0;
  logic [7:0] z_fetch_addr = 0, z_data_addr = 0, z_data_wdata = 0;
  logic       z_fetch_gnt, z_fetch_valid, z_fetch_stall, z_data_gnt, z_data_valid, z_mem_read, z_mem_write;
  logic [7:0] z_fetch_rdata, z_data_rdata, z_mem_addr, z_mem_wdata, z_mem_rdata;

  logic [7:0] rom [256];
  assign mem_rdata   = rom[mem_addr];
  assign z_mem_rdata = rom[z_mem_addr];

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(W), .STARVE_MAX(SM)) u_dut (
    .clock(clock), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_valid(fetch_valid), .fetch_rdata(fetch_rdata), .fetch_stall(fetch_stall),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_gnt(data_gnt), .data_valid(data_valid), .data_rdata(data_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(0), .STARVE_MAX(SM)) u_dut0 (
    .clock(clock), .reset(reset),
    .fetch_req(z_fetch_req), .fetch_addr(z_fetch_addr), .fetch_gnt(z_fetch_gnt),
    .fetch_valid(z_fetch_valid), .fetch_rdata(z_fetch_rdata), .fetch_stall(z_fetch_stall),
    .data_req(z_data_req), .data_we(z_data_we), .data_addr(z_data_addr), .data_wdata(z_data_wdata),
    .data_gnt(z_data_gnt), .data_valid(z_data_valid), .data_rdata(z_data_rdata),
    .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata), .mem_read(z_mem_read), .mem_write(z_mem_write),
    .mem_rdata(z_mem_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    fetch_req  = 0; data_req = 0; data_we = 0; z_data_req = 0;
    reset = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1;
  endtask

  // flags = {fetch_gnt, fetch_valid, fetch_stall, data_gnt, data_valid, mem_read, mem_write}
  typedef struct {
    logic       freq;
    logic [7:0] faddr;
    logic       dreq;
    logic       dwe;
    logic [7:0] daddr;
    logic [7:0] dwd;
    logic [6:0] flags;
    logic [7:0] maddr;
    logic [7:0] frd;
    logic [7:0] drd;
  } vec_t;

  function automatic vec_t mk(logic fq, logic [7:0] fa, logic dq, logic dw, logic [7:0] da,
                              logic [7:0] dd, logic [6:0] fl, logic [7:0] ma, logic [7:0] fr, logic [7:0] dr);
    vec_t v;
    v.freq = fq; v.faddr = fa; v.dreq = dq; v.dwe = dw; v.daddr = da; v.dwd = dd;
    v.flags = fl; v.maddr = ma; v.frd = fr; v.drd = dr;
    return v;
  endfunction

  vec_t tbl [21];

  // random-phase reference model: one outstanding access described by its grant cycle
  int         cyc, t_g, m_starve, dg, fg, dg_before;
  bit         has_t, t_f, t_we, f_pend, d_pend, e_busy, e_fg, e_dg, e_val, free, force_f, gd, gf;
  logic [7:0] t_addr, t_wd, m_frd, m_drd;

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    rom[8'h10] = 8'hA5; rom[8'h11] = 8'h96; rom[8'h20] = 8'h3C;

    // fetch read + re-arbitration, conflict, write
    tbl[0]  = mk(1, 8'h10, 0, 0, 8'h00, 8'h00, 7'b0010000, 8'h00, 8'h00, 8'h00);
    tbl[1]  = mk(1, 8'h10, 0, 0, 8'h00, 8'h00, 7'b1010010, 8'h10, 8'h00, 8'h00);
    tbl[2]  = mk(1, 8'h10, 0, 0, 8'h00, 8'h00, 7'b0010010, 8'h10, 8'h00, 8'h00);
    tbl[3]  = mk(1, 8'h10, 0, 0, 8'h00, 8'h00, 7'b0100000, 8'h00, 8'hA5, 8'h00);
    tbl[4]  = mk(0, 8'h10, 0, 0, 8'h00, 8'h00, 7'b1000010, 8'h10, 8'hA5, 8'h00);
    tbl[5]  = mk(0, 8'h10, 0, 0, 8'h00, 8'h00, 7'b0000010, 8'h10, 8'hA5, 8'h00);
    tbl[6]  = mk(0, 8'h10, 0, 0, 8'h00, 8'h00, 7'b0100000, 8'h00, 8'hA5, 8'h00);
    tbl[7]  = mk(0, 8'h10, 0, 0, 8'h00, 8'h00, 7'b0000000, 8'h00, 8'hA5, 8'h00);
    tbl[8]  = mk(1, 8'h11, 1, 0, 8'h20, 8'h00, 7'b0010000, 8'h00, 8'hA5, 8'h00);
    tbl[9]  = mk(1, 8'h11, 1, 0, 8'h20, 8'h00, 7'b0011010, 8'h20, 8'hA5, 8'h00);
    tbl[10] = mk(1, 8'h11, 0, 0, 8'h20, 8'h00, 7'b0010010, 8'h20, 8'hA5, 8'h00);
    tbl[11] = mk(1, 8'h11, 0, 0, 8'h20, 8'h00, 7'b0010100, 8'h00, 8'hA5, 8'h3C);
    tbl[12] = mk(1, 8'h11, 0, 0, 8'h00, 8'h00, 7'b1010010, 8'h11, 8'hA5, 8'h3C);
    tbl[13] = mk(1, 8'h11, 0, 0, 8'h00, 8'h00, 7'b0010010, 8'h11, 8'hA5, 8'h3C);
    tbl[14] = mk(0, 8'h11, 0, 0, 8'h00, 8'h00, 7'b0100000, 8'h00, 8'h96, 8'h3C);
    tbl[15] = mk(0, 8'h11, 0, 0, 8'h00, 8'h00, 7'b0000000, 8'h00, 8'h96, 8'h3C);
    tbl[16] = mk(0, 8'h11, 1, 1, 8'h30, 8'h5C, 7'b0000000, 8'h00, 8'h96, 8'h3C);
    tbl[17] = mk(0, 8'h11, 1, 1, 8'h30, 8'h5C, 7'b0001001, 8'h30, 8'h96, 8'h3C);
    tbl[18] = mk(0, 8'h11, 0, 1, 8'h30, 8'h5C, 7'b0000001, 8'h30, 8'h96, 8'h3C);
    tbl[19] = mk(0, 8'h11, 0, 0, 8'h30, 8'h5C, 7'b0000100, 8'h00, 8'h96, 8'h3C);
    tbl[20] = mk(0, 8'h11, 0, 0, 8'h00, 8'h00, 7'b0000000, 8'h00, 8'h96, 8'h3C);

    // reset state
    do_reset();
    #1;
    check("rst_flags", {fetch_gnt, fetch_valid, fetch_stall, data_gnt, data_valid, mem_read, mem_write}, 0);
    check("rst_data", {fetch_rdata, data_rdata, mem_addr, mem_wdata}, 0);
    check("rst_z", {z_fetch_gnt, z_fetch_valid, z_fetch_rdata, z_fetch_stall, z_data_gnt, z_data_valid,
                    z_data_rdata, z_mem_addr, z_mem_wdata, z_mem_read, z_mem_write}, 0);

    // table vectors
    for (int k = 0; k < 21; k++) begin
      @(posedge clock); #1;
      fetch_req = tbl[k].freq; fetch_addr = tbl[k].faddr;
      data_req = tbl[k].dreq; data_we = tbl[k].dwe; data_addr = tbl[k].daddr; data_wdata = tbl[k].dwd;
      #1;
      check($sformatf("tbl_flags[%0d]", k),
            {fetch_gnt, fetch_valid, fetch_stall, data_gnt, data_valid, mem_read, mem_write}, tbl[k].flags);
      check($sformatf("tbl_rdata[%0d]", k), {fetch_rdata, data_rdata}, {tbl[k].frd, tbl[k].drd});
      if (tbl[k].flags[1] | tbl[k].flags[0]) check($sformatf("tbl_maddr[%0d]", k), mem_addr, tbl[k].maddr);
      if (tbl[k].flags[0]) check($sformatf("tbl_wdata[%0d]", k), mem_wdata, tbl[k].dwd);
    end

    // reset in the middle of a fetch
    do_reset();
    fetch_addr = 8'h42; fetch_req = 1;
    @(posedge clock); #1;
    check("mid_gnt", {fetch_gnt, mem_read}, 2'b11);
    @(posedge clock); #3;
    reset = 0;
    #1;
    check("mid_strobe_drop", {mem_read, mem_write, fetch_gnt, fetch_valid}, 0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      check("mid_no_valid", fetch_valid, 0);
    end
    @(negedge clock);
    reset = 1;
    @(posedge clock); #1;
    check("mid_regrant", {fetch_gnt, mem_read, mem_addr}, {2'b11, 8'h42});
    @(posedge clock); @(posedge clock); #1;
    check("mid_valid", {fetch_valid, fetch_rdata}, {1'b1, rom[8'h42]});
    fetch_req = 0;

    // zero wait states, back-to-back data reads
    do_reset();
    z_data_req = 1; z_data_we = 0; z_data_addr = 8'h20;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clock); #1;
      check($sformatf("w0_gnt[%0d]", c), z_data_gnt, (c % 2) == 1);
      check($sformatf("w0_valid[%0d]", c), z_data_valid, (c % 2) == 0);
      if ((c % 2) == 0) check($sformatf("w0_rdata[%0d]", c), z_data_rdata, 8'h3C);
    end
    z_data_req = 0;

    // both requesters held continuously
    do_reset();
    fetch_addr = 8'h10; data_addr = 8'h20; data_we = 0;
    fetch_req = 1; data_req = 1;
    dg = 0; fg = 0; dg_before = -1;
    for (int c = 1; c <= 24; c++) begin
      @(posedge clock); #1;
      if (fetch_gnt && fg == 0) dg_before = dg;
      dg += int'(data_gnt);
      fg += int'(fetch_gnt);
    end
`ifdef MEM_ARB_STARVE_GUARD_EN
    check("starve_dg_before_fg", dg_before, SM);
    check("starve_fg_seen", fg > 0, 1);
`else
    check("strict_no_fg", fg, 0);
    check("strict_dg", dg, 8);
`endif
    fetch_req = 0; data_req = 0;

    // randomized traffic against the transaction model
    do_reset();
    has_t = 0; t_f = 0; t_we = 0; t_g = 0; t_addr = 0; t_wd = 0;
    m_frd = 0; m_drd = 0; m_starve = 0; cyc = 0; f_pend = 0; d_pend = 0;
    for (int n = 0; n < 2000; n++) begin
      @(posedge clock); #1;
      cyc++;
      e_busy = has_t && cyc >= t_g && cyc <= t_g + W;
      e_fg   = has_t && t_f && cyc == t_g;
      e_dg   = has_t && !t_f && cyc == t_g;
      e_val  = has_t && cyc == t_g + W + 1;
      if (e_val && !t_we) begin
        if (t_f) m_frd = rom[t_addr];
        else     m_drd = rom[t_addr];
      end
      check("rnd_flags", {fetch_gnt, fetch_valid, data_gnt, data_valid, mem_read, mem_write},
            {e_fg, e_val & t_f, e_dg, e_val & !t_f, e_busy & !t_we, e_busy & t_we});
      check("rnd_rdata", {fetch_rdata, data_rdata}, {m_frd, m_drd});
      if (e_busy) check("rnd_maddr", mem_addr, t_addr);
      if (e_busy && t_we) check("rnd_wdata", mem_wdata, t_wd);

      if (e_fg) f_pend = 0;
      if (e_dg) d_pend = 0;
      if (!f_pend && $urandom_range(0, 2) == 0) begin
        f_pend = 1; fetch_addr = 8'($urandom);
      end
      if (!d_pend && $urandom_range(0, 3) == 0) begin
        d_pend = 1; data_we = 1'($urandom); data_addr = 8'($urandom); data_wdata = 8'($urandom);
      end
      fetch_req = f_pend; data_req = d_pend;
      #1;
      check("rnd_stall", fetch_stall, fetch_req & ~(e_val & t_f));

      free = !has_t || cyc >= t_g + W + 1;
`ifdef MEM_ARB_STARVE_GUARD_EN
      force_f = fetch_req && m_starve == SM;
`else
      force_f = 0;
`endif
      gd = free && data_req && !force_f;
      gf = free && fetch_req && !gd;
      if (gd || gf) begin
        has_t = 1; t_f = gf; t_g = cyc + 1;
        t_we   = gf ? 1'b0 : data_we;
        t_addr = gf ? fetch_addr : data_addr;
        t_wd   = data_wdata;
      end
      if (!fetch_req || gf) m_starve = 0;
      else if (gd)          m_starve++;
    end
    fetch_req = 0; data_req = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
